// File: rtl/imp_200_rx_if.sv
// Output bundle of the imp_200_rx receiver: recovered bit stream, lock status and error reporting.
interface imp_200_rx_if;
  logic        bit_valid;
  logic        bit_out;
  logic        locked;
  logic        seq_start;
  logic        phase_err;
  logic [15:0] err_cnt;

  modport master (output bit_valid, bit_out, locked, seq_start, phase_err, err_cnt);
  modport slave  (input  bit_valid, bit_out, locked, seq_start, phase_err, err_cnt);
endinterface

// File: rtl/imp_200_rx.sv
// RZ pulse-train receiver: slot recovery, sequence search and locked bit checking.
// Optional feature: define IMP_200_RX_ERRCNT_EN to enable the cumulative err_cnt output.
//
// state  | meaning
// IDLE   | no pulse activity; slot counter held at 0
// SYNC   | slots running; recovered bits shift into the search window
// LOCK   | window matched reference; bits checked against reference per index
module imp_200_rx #(
  parameter int SLOT_LEN = 11,
  parameter int SEQ_LEN  = 64,
  parameter int MAX_ERR  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_imp,
  input  logic [69:0] m_seq_ref,
  imp_200_rx_if.master rx
);

  localparam int                SW         = $clog2(SLOT_LEN);
  localparam logic [SW-1:0]     SLOT_LAST  = SW'(SLOT_LEN - 1);
  localparam logic [6:0]        IDX_LAST   = 7'(SEQ_LEN - 1);
  localparam logic [7:0]        QUIET_LAST = 8'(2 * SEQ_LEN - 1);
  localparam logic [6:0]        ERR_LIM    = 7'(MAX_ERR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_sync1, r_sync2, r_sync3;
  logic [SW-1:0]      r_slot;
  logic               r_seen;
  logic [7:0]         r_quiet;
  logic [SEQ_LEN-1:0] r_win;
  logic [6:0]         r_idx;
  logic [6:0]         r_perr;
  logic               r_bit_valid, r_bit_out, r_seq_start, r_phase_err;
  logic               w_locked;

  logic               w_edge, w_close, w_timeout, w_match, w_mis, w_wrap, w_over;
  logic [SEQ_LEN-1:0] w_win_next;
  logic [6:0]         w_perr_next;

  assign w_edge      = r_sync2 & ~r_sync3;
  assign w_close     = (r_state != S_IDLE) && (r_slot == SLOT_LAST);
  // An edge landing on the closing cycle counts as activity, so it vetoes the timeout.
  assign w_timeout   = w_close && !r_seen && !w_edge && (r_quiet == QUIET_LAST);
  assign w_win_next  = {r_seen, r_win[SEQ_LEN-1:1]};
  assign w_match     = (w_win_next == m_seq_ref[SEQ_LEN-1:0]);
  assign w_mis       = (r_seen != m_seq_ref[r_idx]);
  assign w_wrap      = (r_idx == IDX_LAST);
  assign w_perr_next = r_perr + {6'd0, w_mis};
  assign w_over      = (w_perr_next > ERR_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_edge) w_state_next = S_SYNC;
      S_SYNC: begin
        if (w_timeout)              w_state_next = S_IDLE;
        else if (w_close && w_match) w_state_next = S_LOCK;
      end
      S_LOCK: begin
        if (w_timeout)                       w_state_next = S_IDLE;
        else if (w_close && w_wrap && w_over) w_state_next = S_SYNC;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_locked = 1'b0;
    if (r_state == S_LOCK) w_locked = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync3     <= 1'b0;
      r_slot      <= '0;
      r_seen      <= 1'b0;
      r_quiet     <= '0;
      r_win       <= '0;
      r_idx       <= '0;
      r_perr      <= '0;
      r_bit_valid <= 1'b0;
      r_bit_out   <= 1'b0;
      r_seq_start <= 1'b0;
      r_phase_err <= 1'b0;
    end else begin
      r_sync1 <= in_imp;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;

      if (w_edge)                            r_slot <= SW'(1);
      else if (r_state == S_IDLE || w_close) r_slot <= '0;
      else                                   r_slot <= r_slot + SW'(1);

      if (w_edge)       r_seen <= 1'b1;
      else if (w_close) r_seen <= 1'b0;

      // Close is evaluated before the edge restarts the slot, so a coincident edge never loses the bit.
      r_bit_valid <= w_close;
      r_bit_out   <= w_close & r_seen;
      r_seq_start <= w_close && (r_state == S_LOCK) && (r_idx == 7'd0);
      r_phase_err <= w_edge && (r_state != S_IDLE) && (r_slot != '0);

      if (w_edge || w_timeout || r_state == S_IDLE) r_quiet <= '0;
      else if (w_close && !r_seen)                  r_quiet <= r_quiet + 8'd1;

      if (w_timeout) begin
        r_win  <= '0;
        r_idx  <= '0;
        r_perr <= '0;
      end else if (w_close && r_state == S_SYNC) begin
        r_win <= w_win_next;
        if (w_match) begin
          r_idx  <= '0;
          r_perr <= '0;
        end
      end else if (w_close && r_state == S_LOCK) begin
        if (w_wrap) begin
          r_idx  <= '0;
          r_perr <= '0;
          if (w_over) r_win <= '0;
        end else begin
          r_idx  <= r_idx + 7'd1;
          r_perr <= w_perr_next;
        end
      end
    end
  end

`ifdef IMP_200_RX_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_err_cnt <= '0;
    else if (w_close && r_state == S_LOCK && w_mis && r_err_cnt != 16'hFFFF)
      r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign rx.err_cnt = r_err_cnt;
`else
  assign rx.err_cnt = 16'h0000;
`endif

  assign rx.bit_valid = r_bit_valid;
  assign rx.bit_out   = r_bit_out;
  assign rx.seq_start = r_seq_start;
  assign rx.phase_err = r_phase_err;
  assign rx.locked    = w_locked;

endmodule

// File: tb/tb_imp_200_rx.sv
// Bench for imp_200_rx: scoreboard of sent bits plus a bit-level lock model checked on every bit_valid.
// Expected err_cnt follows IMP_200_RX_ERRCNT_EN when the bench is built with it.
module tb_imp_200_rx;
  localparam int SLOT_LEN = 11;
  localparam int SEQ_LEN  = 64;
  localparam int MAX_ERR  = 4;
`ifdef IMP_200_RX_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_imp = 1'b0;
  logic [69:0] m_seq_ref;
  logic [63:0] ref_bits;

  imp_200_rx_if rx ();

  imp_200_rx #(.SLOT_LEN(SLOT_LEN), .SEQ_LEN(SEQ_LEN), .MAX_ERR(MAX_ERR)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_imp   (in_imp),
    .m_seq_ref(m_seq_ref),
    .rx       (rx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  bit sb[$];
  int m_state, m_idx, m_perr, m_err, m_zero;
  logic [63:0] m_win;
  int n_phase = 0, n_drop = 0, first_bv_cyc = -1, ss_prev = -1, ss_gap = 0;
  bit prev_locked = 1'b0;
  bit s_active = 1'b0;
  int s_zero = 0;
  bit mon_b, mon_ss;
  logic [15:0] mon_err;

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_perr = 0; m_err = 0; m_zero = 0; m_win = '0;
  endtask

  // Behavioural model of the lock protocol, advanced once per emitted bit.
  task automatic model_step(input bit b, output bit exp_ss);
    exp_ss = (m_state == 2) && (m_idx == 0);
    if (m_state == 0) m_state = 1;
    m_zero = b ? 0 : m_zero + 1;
    if (m_state == 1) begin
      m_win = {b, m_win[63:1]};
      if (m_win == ref_bits) begin
        m_state = 2; m_idx = 0; m_perr = 0;
      end
    end else begin
      if (b != ref_bits[m_idx]) begin
        m_perr++;
        if (m_err < 65535) m_err++;
      end
      if (m_idx == SEQ_LEN - 1) begin
        m_idx = 0;
        if (m_perr > MAX_ERR) begin m_state = 1; m_win = '0; end
        m_perr = 0;
      end else m_idx++;
    end
    if (m_zero == 2 * SEQ_LEN) begin
      m_state = 0; m_win = '0; m_idx = 0; m_perr = 0; m_zero = 0;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (rx.phase_err) n_phase++;
      if (prev_locked && !rx.locked) n_drop++;
      prev_locked = rx.locked;
      if (rx.seq_start) begin
        if (ss_prev >= 0) ss_gap = cyc - ss_prev;
        ss_prev = cyc;
      end
      if (rx.bit_valid) begin
        if (first_bv_cyc < 0) first_bv_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bit_valid at cycle %0d: got strobe (bit_out=%0b), expected none", cyc, rx.bit_out);
        end else begin
          mon_b = sb.pop_front();
          model_step(mon_b, mon_ss);
          mon_err = ERRCNT ? 16'(m_err) : 16'h0000;
          checks += 4;
          if (rx.bit_out !== mon_b) begin
            errors++;
            $display("FAIL bit_out at cycle %0d: got %0b expected %0b", cyc, rx.bit_out, mon_b);
          end
          if (rx.seq_start !== mon_ss) begin
            errors++;
            $display("FAIL seq_start at cycle %0d: got %0b expected %0b", cyc, rx.seq_start, mon_ss);
          end
          if (rx.locked !== (m_state == 2)) begin
            errors++;
            $display("FAIL locked_model at cycle %0d: got %0b expected %0b", cyc, rx.locked, (m_state == 2));
          end
          if (rx.err_cnt !== mon_err) begin
            errors++;
            $display("FAIL err_cnt_model at cycle %0d: got %0d expected %0d", cyc, rx.err_cnt, mon_err);
          end
        end
      end
    end
  end

  // One slot starting at a negedge; keep=0 marks a slot the receiver must discard.
  task automatic send_slot(input bit b, input int len, input bit keep);
    if (keep) begin
      if (b) begin
        s_active = 1'b1; s_zero = 0; sb.push_back(b);
      end else if (s_active) begin
        sb.push_back(b);
        s_zero++;
        if (s_zero == 2 * SEQ_LEN) s_active = 1'b0;
      end
    end else if (b) s_zero = 0;
    in_imp = b;
    repeat (3) @(negedge clk);
    in_imp = 1'b0;
    repeat (len - 3) @(negedge clk);
  endtask

  task automatic send_period(input logic [63:0] flips);
    for (int i = 0; i < SEQ_LEN; i++) send_slot(ref_bits[i] ^ flips[i], SLOT_LEN, 1'b1);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d bits still pending, expected 0", tag, sb.size());
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks += 6;
    if (rx.bit_valid !== 1'b0) begin errors++; $display("FAIL %s_bit_valid: got %0b expected 0", tag, rx.bit_valid); end
    if (rx.bit_out   !== 1'b0) begin errors++; $display("FAIL %s_bit_out: got %0b expected 0", tag, rx.bit_out); end
    if (rx.locked    !== 1'b0) begin errors++; $display("FAIL %s_locked: got %0b expected 0", tag, rx.locked); end
    if (rx.seq_start !== 1'b0) begin errors++; $display("FAIL %s_seq_start: got %0b expected 0", tag, rx.seq_start); end
    if (rx.phase_err !== 1'b0) begin errors++; $display("FAIL %s_phase_err: got %0b expected 0", tag, rx.phase_err); end
    if (rx.err_cnt   !== 16'h0) begin errors++; $display("FAIL %s_err_cnt: got %0d expected 0", tag, rx.err_cnt); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_lock();
    int c0;
    first_bv_cyc = -1;
    c0 = cyc;
    send_period('0);
    checks++;
    if (rx.locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %0b expected 0", rx.locked); end
    send_period('0);
    checks += 2;
    if (rx.locked !== 1'b1) begin errors++; $display("FAIL lock_after_period: got %0b expected 1", rx.locked); end
    if (first_bv_cyc - c0 !== SLOT_LEN + 2) begin
      errors++;
      $display("FAIL first_bit_latency: got %0d expected %0d", first_bv_cyc - c0, SLOT_LEN + 2);
    end
    send_period('0);
    checks += 3;
    if (ss_gap !== SLOT_LEN * SEQ_LEN) begin errors++; $display("FAIL seq_start_gap: got %0d expected %0d", ss_gap, SLOT_LEN * SEQ_LEN); end
    if (rx.err_cnt !== 16'h0) begin errors++; $display("FAIL clean_err_cnt: got %0d expected 0", rx.err_cnt); end
    if (n_phase !== 0) begin errors++; $display("FAIL clean_phase_err: got %0d expected 0", n_phase); end
  endtask

  task automatic test_bit_errors();
    logic [63:0] f3, f5;
    int d0;
    f3 = '0; f3[5] = 1'b1; f3[17] = 1'b1; f3[40] = 1'b1;
    f5 = '0; f5[2] = 1'b1; f5[10] = 1'b1; f5[20] = 1'b1; f5[30] = 1'b1; f5[50] = 1'b1;
    d0 = n_drop;
    send_period(f3);
    checks += 2;
    if (rx.locked !== 1'b1) begin errors++; $display("FAIL three_flips_locked: got %0b expected 1", rx.locked); end
    if (rx.err_cnt !== (ERRCNT ? 16'd3 : 16'd0)) begin
      errors++; $display("FAIL three_flips_err_cnt: got %0d expected %0d", rx.err_cnt, ERRCNT ? 3 : 0);
    end
    send_period(f5);
    send_period('0);
    checks += 3;
    if (rx.locked !== 1'b0) begin errors++; $display("FAIL five_flips_unlock: got %0b expected 0", rx.locked); end
    if (n_drop - d0 !== 1) begin errors++; $display("FAIL five_flips_drops: got %0d expected 1", n_drop - d0); end
    if (rx.err_cnt !== (ERRCNT ? 16'd8 : 16'd0)) begin
      errors++; $display("FAIL five_flips_err_cnt: got %0d expected %0d", rx.err_cnt, ERRCNT ? 8 : 0);
    end
    send_period('0);
    checks++;
    if (rx.locked !== 1'b1) begin errors++; $display("FAIL relock_after_flips: got %0b expected 1", rx.locked); end
  endtask

  task automatic test_phase_shift();
    int k = -1, p0, d0;
    for (int i = 20; i < SEQ_LEN; i++) if (ref_bits[i] && k < 0) k = i;
    p0 = n_phase;
    d0 = n_drop;
    // Pulse k arrives 4 cycles early and the whole train keeps the new phase.
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (i == k - 1) send_slot(ref_bits[i], SLOT_LEN - 4, 1'b0);
      else            send_slot(ref_bits[i], SLOT_LEN, 1'b1);
    end
    checks++;
    if (n_phase - p0 !== 1) begin errors++; $display("FAIL phase_err_count: got %0d expected 1", n_phase - p0); end
    send_period('0);
    checks++;
    if (n_drop - d0 !== 1) begin errors++; $display("FAIL phase_lock_drop: got %0d expected 1", n_drop - d0); end
    send_period('0);
    send_period('0);
    checks += 2;
    if (rx.locked !== 1'b1) begin errors++; $display("FAIL phase_relock: got %0b expected 1", rx.locked); end
    if (n_phase - p0 !== 1) begin errors++; $display("FAIL phase_err_after: got %0d expected 1", n_phase - p0); end
  endtask

  task automatic test_timeout();
    logic [15:0] e;
    int p0;
    for (int i = 0; i < 2 * SEQ_LEN; i++) send_slot(1'b0, SLOT_LEN, 1'b1);
    drain("timeout");
    e = ERRCNT ? 16'(m_err) : 16'h0000;
    p0 = n_phase;
    checks += 2;
    if (rx.locked !== 1'b0) begin errors++; $display("FAIL timeout_locked: got %0b expected 0", rx.locked); end
    if (rx.err_cnt !== e) begin errors++; $display("FAIL timeout_err_cnt: got %0d expected %0d", rx.err_cnt, e); end
    repeat (20 * SLOT_LEN) @(negedge clk);
    checks += 2;
    if (rx.err_cnt !== e) begin errors++; $display("FAIL idle_err_cnt_hold: got %0d expected %0d", rx.err_cnt, e); end
    if (n_phase !== p0) begin errors++; $display("FAIL idle_phase_err: got %0d expected %0d", n_phase - p0, 0); end
    send_period('0);
    send_period('0);
    checks++;
    if (rx.locked !== 1'b1) begin errors++; $display("FAIL relock_from_idle: got %0b expected 1", rx.locked); end
  endtask

  task automatic test_reset_mid_slot();
    for (int i = 0; i < 10; i++) send_slot(ref_bits[i], SLOT_LEN, 1'b1);
    in_imp = 1'b1;
    repeat (3) @(negedge clk);
    in_imp = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    model_reset();
    s_active = 1'b0;
    s_zero = 0;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3 * SLOT_LEN) @(negedge clk);
    checks += 2;
    if (rx.locked !== 1'b0) begin errors++; $display("FAIL post_reset_locked: got %0b expected 0", rx.locked); end
    if (rx.err_cnt !== 16'h0) begin errors++; $display("FAIL post_reset_err_cnt: got %0d expected 0", rx.err_cnt); end
  endtask

  task automatic test_back_to_back();
    send_period('0);
    send_period('0);
    checks++;
    if (rx.locked !== 1'b1) begin errors++; $display("FAIL restart_lock: got %0b expected 1", rx.locked); end
    drain("end");
  endtask

  initial begin
    logic [5:0] lfsr;
    lfsr = 6'd1;
    for (int i = 0; i < 64; i++) begin
      ref_bits[i] = lfsr[0];
      lfsr = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
    end
    m_seq_ref = {6'd0, ref_bits};
    model_reset();
    @(negedge clk);
    test_reset();
    test_lock();
    test_bit_errors();
    test_phase_shift();
    test_timeout();
    test_reset_mid_slot();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
